uart_bus_requester: RTL and testbench

- Host-side counterpart of the UART system controller: turns parallel bus requests into the UART command byte stream and collects the response bytes.
- The command stream is read/write, address, then data. Responses are read data or a write ack.
- Sits between a requester (test sequencer or debug CPU) and a uart_tx/uart_rx pair, connected over 8-bit AXI-Stream.
- One transaction is outstanding at a time. A response timeout reports a dead link.

---
 rtl/uart_bus_requester_if.sv | 33 +++
 rtl/uart_bus_requester.sv | 156 +++++++++++++++
 tb/tb_uart_bus_requester.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_requester_if.sv
// rtl/uart_bus_requester_if.sv - request/response and byte-stream bundle for uart_bus_requester
interface uart_bus_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [7:0]        m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [7:0]        s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              busy;

    // Requester block view: takes requests and the rx stream, drives tx and responses
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, m_axis_tready, s_axis_tdata, s_axis_tvalid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, m_axis_tdata, m_axis_tvalid, s_axis_tready, busy
    );

    // Sequencer / uart-pair view
    modport master (
        output req_valid, req_we, req_addr, req_wdata, m_axis_tready, s_axis_tdata, s_axis_tvalid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, m_axis_tdata, m_axis_tvalid, s_axis_tready, busy
    );
endinterface

// File: rtl/uart_bus_requester.sv
// rtl/uart_bus_requester.sv - bus request to UART command frame, response collection with timeout
module uart_bus_requester #(
    parameter int         ADDR_W   = 32,
    parameter int         DATA_W   = 32,
    parameter int         TIMEOUT  = 1000000,
    parameter logic [7:0] ACK_BYTE = 8'h06
) (
    input logic                clk,
    input logic                rst_n,
    uart_bus_requester_if.slave bus
);
    localparam int CNT_W      = 8;
    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, SEND_HDR, SEND_ADDR, SEND_DATA, WAIT_RSP, DONE} state_t;

    state_t            state, state_n;
    logic              we_q;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] data_sh;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_shift;
    logic [CNT_W-1:0]  cnt;
    logic [TO_W-1:0]   tcnt;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              req_ready_c, m_tvalid_c, s_tready_c, rsp_valid_c;
    logic [7:0]        m_tdata_c;
    logic              rx_complete, rx_timeout;
    logic              addr_last, data_last;

    assign acc_shift = (acc << 8) | DATA_W'(bus.s_axis_tdata);
    assign addr_last = (cnt == CNT_W'(ADDR_BYTES - 1));
    assign data_last = (cnt == CNT_W'(DATA_BYTES - 1));

    // State register; async reset abandons any partial frame without a response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state and handshake outputs
    always_comb begin
        state_n     = state;
        req_ready_c = 1'b0;
        m_tvalid_c  = 1'b0;
        m_tdata_c   = 8'h00;
        s_tready_c  = 1'b0;
        rsp_valid_c = 1'b0;
        rx_complete = 1'b0;
        rx_timeout  = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                s_tready_c  = 1'b1;      // stray rx bytes are drained and dropped
                if (bus.req_valid) state_n = SEND_HDR;
            end
            SEND_HDR: begin
                m_tvalid_c = 1'b1;
                m_tdata_c  = we_q ? 8'h57 : 8'h52;
                if (bus.m_axis_tready) state_n = SEND_ADDR;
            end
            SEND_ADDR: begin
                m_tvalid_c = 1'b1;
                m_tdata_c  = addr_sh[ADDR_W-1 -: 8];
                if (bus.m_axis_tready && addr_last) state_n = we_q ? SEND_DATA : WAIT_RSP;
            end
            SEND_DATA: begin
                m_tvalid_c = 1'b1;
                m_tdata_c  = data_sh[DATA_W-1 -: 8];
                if (bus.m_axis_tready && data_last) state_n = WAIT_RSP;
            end
            WAIT_RSP: begin
                s_tready_c = 1'b1;
                // a completing byte takes priority over a coincident timeout
                if (bus.s_axis_tvalid && (we_q || data_last)) begin
                    rx_complete = 1'b1;
                    state_n     = DONE;
                end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                    rx_timeout = 1'b1;
                    state_n    = DONE;
                end
            end
            DONE: begin
                rsp_valid_c = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latch, byte shifters, counters and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            addr_sh     <= '0;
            data_sh     <= '0;
            acc         <= '0;
            cnt         <= '0;
            tcnt        <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            tcnt <= (state == WAIT_RSP) ? tcnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_sh <= bus.req_addr;
                        data_sh <= bus.req_wdata;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                SEND_ADDR: begin
                    if (bus.m_axis_tready) begin
                        addr_sh <= addr_sh << 8;
                        cnt     <= addr_last ? '0 : cnt + 1'b1;
                    end
                end
                SEND_DATA: begin
                    if (bus.m_axis_tready) begin
                        data_sh <= data_sh << 8;
                        cnt     <= data_last ? '0 : cnt + 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (bus.s_axis_tvalid) begin
                        acc <= acc_shift;
                        cnt <= cnt + 1'b1;
                    end
                    if (rx_complete) begin
                        rsp_rdata_q <= we_q ? '0 : acc_shift;
                        rsp_err_q   <= we_q && (bus.s_axis_tdata != ACK_BYTE);
                    end else if (rx_timeout) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_c;
    assign bus.m_axis_tvalid = m_tvalid_c;
    assign bus.m_axis_tdata  = m_tdata_c;
    assign bus.s_axis_tready = s_tready_c;
    assign bus.rsp_valid     = rsp_valid_c;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_uart_bus_requester.sv
// tb/tb_uart_bus_requester.sv - scoreboard bench for uart_bus_requester
module tb_uart_bus_requester;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_bus_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    uart_bus_requester #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .ACK_BYTE(8'h06)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  tx_exp[$];
    logic [7:0]  tx_got[$];
    logic [7:0]  rx_src[$];
    logic [31:0] exp_rdata[$];
    logic        exp_err[$];

    logic [31:0] got_rdata;
    logic        got_err;
    logic        busy_after;
    int rsp_pulses, viol, acc_cycle, first_tv_cycle, last_tx_cycle, last_rx_cycle, rsp_cycle;

    // Reference frame builder: header, address MSB first, then data for writes
    task automatic push_frame(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        tx_exp.push_back(we ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) tx_exp.push_back(addr[8*i +: 8]);
        if (we) for (int i = 3; i >= 0; i--) tx_exp.push_back(wdata[8*i +: 8]);
    endtask

    // Drives one request, plays uart_tx/uart_rx, records what the DUT produced
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int stall_pct, input logic respond);
        logic       pend, accepted;
        logic [7:0] pend_d;
        int         rx_i, frame_len;
        frame_len = we ? 9 : 5;
        tx_got.delete();
        rsp_pulses = 0; viol = 0; acc_cycle = -1; first_tv_cycle = -1;
        last_tx_cycle = -1; last_rx_cycle = -1; rsp_cycle = -1;
        pend = 1'b0; pend_d = 8'h00; accepted = 1'b0; rx_i = 0; busy_after = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (accepted) bus.req_valid = 1'b0;
            if (pend && (!bus.m_axis_tvalid || bus.m_axis_tdata !== pend_d)) viol++;
            if (accepted && first_tv_cycle < 0 && bus.m_axis_tvalid) first_tv_cycle = cyc;
            if (bus.rsp_valid) begin
                rsp_pulses++;
                if (rsp_cycle < 0) begin
                    rsp_cycle = cyc; got_rdata = bus.rsp_rdata; got_err = bus.rsp_err;
                end
            end
            if (rsp_cycle >= 0 && cyc == rsp_cycle + 1) busy_after = bus.busy;
            if (rsp_cycle >= 0 && cyc == rsp_cycle + 4) break;
            bus.m_axis_tready = ($urandom_range(99) >= stall_pct);
            if (respond && tx_got.size() == frame_len && rx_i < rx_src.size()) begin
                bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = rx_src[rx_i];
            end else begin
                bus.s_axis_tvalid = 1'b0;
            end
            if (bus.req_valid && bus.req_ready && !accepted) begin accepted = 1'b1; acc_cycle = cyc; end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                tx_got.push_back(bus.m_axis_tdata); last_tx_cycle = cyc; pend = 1'b0;
            end else begin
                pend = bus.m_axis_tvalid; pend_d = bus.m_axis_tdata;
            end
            if (bus.s_axis_tvalid && bus.s_axis_tready) begin rx_i++; last_rx_cycle = cyc; end
            @(negedge clk);
        end
        bus.req_valid = 1'b0; bus.s_axis_tvalid = 1'b0; bus.m_axis_tready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        checks++; if ({bus.m_axis_tvalid, bus.m_axis_tdata} !== 9'h000) begin failures++; $display("FAIL reset_m_axis got=%b/%02h exp=0/00", bus.m_axis_tvalid, bus.m_axis_tdata); end
        checks++; if (bus.s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_s_tready got=%b exp=1", bus.s_axis_tready); end
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.busy} !== 3'b000) begin failures++; $display("FAIL reset_rsp_busy got=%b exp=000", {bus.rsp_valid, bus.rsp_err, bus.busy}); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rsp_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        logic [7:0] e, g;
        push_frame(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        exp_rdata.push_back(32'h0); exp_err.push_back(1'b0);
        rx_src = '{8'h06};
        run_txn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b1);
        checks++; if (tx_got.size() != tx_exp.size()) begin failures++; $display("FAIL write_len got=%0d exp=%0d", tx_got.size(), tx_exp.size()); end
        while (tx_exp.size() > 0) begin
            e = tx_exp.pop_front(); g = (tx_got.size() > 0) ? tx_got.pop_front() : 8'hxx;
            checks++; if (g !== e) begin failures++; $display("FAIL write_tx_byte got=%02h exp=%02h", g, e); end
        end
        checks++; if (rsp_pulses != 1) begin failures++; $display("FAIL write_pulses got=%0d exp=1", rsp_pulses); end
        e = {7'b0, exp_err.pop_front()};
        checks++; if ({got_rdata, got_err} !== {exp_rdata.pop_front(), e[0]}) begin failures++; $display("FAIL write_rsp got=%h/%b exp=0/0", got_rdata, got_err); end
        checks++; if (first_tv_cycle - acc_cycle != 1) begin failures++; $display("FAIL write_req_latency got=%0d exp=1", first_tv_cycle - acc_cycle); end
        checks++; if (rsp_cycle - last_rx_cycle != 1) begin failures++; $display("FAIL write_rsp_latency got=%0d exp=1", rsp_cycle - last_rx_cycle); end
    endtask

    task automatic test_read;
        logic [7:0] e, g;
        push_frame(1'b0, 32'h20, 32'h0);
        exp_rdata.push_back(32'h1234_5678); exp_err.push_back(1'b0);
        rx_src = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_txn(1'b0, 32'h20, 32'hFFFF_FFFF, 0, 1'b1);
        checks++; if (tx_got.size() != tx_exp.size()) begin failures++; $display("FAIL read_len got=%0d exp=%0d", tx_got.size(), tx_exp.size()); end
        while (tx_exp.size() > 0) begin
            e = tx_exp.pop_front(); g = (tx_got.size() > 0) ? tx_got.pop_front() : 8'hxx;
            checks++; if (g !== e) begin failures++; $display("FAIL read_tx_byte got=%02h exp=%02h", g, e); end
        end
        checks++; if (rsp_pulses != 1) begin failures++; $display("FAIL read_pulses got=%0d exp=1", rsp_pulses); end
        e = {7'b0, exp_err.pop_front()};
        checks++; if ({got_rdata, got_err} !== {exp_rdata.pop_front(), e[0]}) begin failures++; $display("FAIL read_rsp got=%h/%b exp=12345678/0", got_rdata, got_err); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL read_busy_after got=%b exp=0", busy_after); end
        checks++; if (rsp_cycle - last_rx_cycle != 1) begin failures++; $display("FAIL read_rsp_latency got=%0d exp=1", rsp_cycle - last_rx_cycle); end
    endtask

    task automatic test_stall;
        logic [7:0]  e, g;
        logic [31:0] a, d;
        for (int k = 0; k < 3; k++) begin
            a = $urandom; d = $urandom;
            push_frame(1'b1, a, d);
            exp_rdata.push_back(32'h0); exp_err.push_back(1'b0);
            rx_src = '{8'h06};
            run_txn(1'b1, a, d, 50, 1'b1);
            checks++; if (viol != 0) begin failures++; $display("FAIL stall_hold_violations got=%0d exp=0", viol); end
            checks++; if (tx_got.size() != tx_exp.size()) begin failures++; $display("FAIL stall_len got=%0d exp=%0d", tx_got.size(), tx_exp.size()); end
            while (tx_exp.size() > 0) begin
                e = tx_exp.pop_front(); g = (tx_got.size() > 0) ? tx_got.pop_front() : 8'hxx;
                checks++; if (g !== e) begin failures++; $display("FAIL stall_tx_byte got=%02h exp=%02h", g, e); end
            end
            e = {7'b0, exp_err.pop_front()};
            checks++; if (rsp_pulses != 1 || {got_rdata, got_err} !== {exp_rdata.pop_front(), e[0]}) begin
                failures++; $display("FAIL stall_rsp got=%0d/%h/%b exp=1/0/0", rsp_pulses, got_rdata, got_err);
            end
        end
    endtask

    task automatic test_errors;
        logic [7:0] e;
        exp_rdata.push_back(32'h0); exp_err.push_back(1'b1);
        rx_src = '{8'h15};
        run_txn(1'b1, 32'h40, 32'h1111_2222, 0, 1'b1);
        e = {7'b0, exp_err.pop_front()};
        checks++; if (rsp_pulses != 1 || {got_rdata, got_err} !== {exp_rdata.pop_front(), e[0]}) begin
            failures++; $display("FAIL bad_ack_rsp got=%0d/%h/%b exp=1/0/1", rsp_pulses, got_rdata, got_err);
        end
        exp_rdata.push_back(32'h0); exp_err.push_back(1'b1);
        rx_src.delete();
        run_txn(1'b0, 32'h80, 32'h0, 0, 1'b0);
        e = {7'b0, exp_err.pop_front()};
        checks++; if (rsp_pulses != 1 || {got_rdata, got_err} !== {exp_rdata.pop_front(), e[0]}) begin
            failures++; $display("FAIL timeout_rsp got=%0d/%h/%b exp=1/0/1", rsp_pulses, got_rdata, got_err);
        end
        checks++; if (rsp_cycle - (last_tx_cycle + 1) != TIMEOUT) begin
            failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", rsp_cycle - (last_tx_cycle + 1), TIMEOUT);
        end
        tx_exp.delete();
    endtask

    task automatic test_stray;
        logic [7:0] e;
        rx_src = '{8'hAA, 8'hBB};
        foreach (rx_src[i]) begin
            @(negedge clk);
            bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = rx_src[i];
            checks++; if (bus.s_axis_tready !== 1'b1) begin failures++; $display("FAIL stray_tready got=%b exp=1", bus.s_axis_tready); end
        end
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        exp_rdata.push_back(32'h9ABC_DEF0); exp_err.push_back(1'b0);
        rx_src = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_txn(1'b0, 32'h0000_0C00, 32'h0, 0, 1'b1);
        e = {7'b0, exp_err.pop_front()};
        checks++; if (rsp_pulses != 1 || {got_rdata, got_err} !== {exp_rdata.pop_front(), e[0]}) begin
            failures++; $display("FAIL stray_rsp got=%0d/%h/%b exp=1/9abcdef0/0", rsp_pulses, got_rdata, got_err);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] e;
        int         pulses;
        @(negedge clk);
        bus.m_axis_tready = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h0102_0304; bus.req_wdata = 32'h0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 8'h02) begin
            failures++; $display("FAIL mid_send_addr got=%b/%02h exp=1/02", bus.m_axis_tvalid, bus.m_axis_tdata);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.m_axis_tvalid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL mid_reset_abort got=%b/%b exp=0/0", bus.m_axis_tvalid, bus.busy);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.rsp_valid) pulses++; end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.rsp_valid) pulses++; end
        checks++; if (pulses != 0) begin failures++; $display("FAIL mid_reset_pulses got=%0d exp=0", pulses); end
        exp_rdata.push_back(32'hCAFE_F00D); exp_err.push_back(1'b0);
        rx_src = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        run_txn(1'b0, 32'h44, 32'h0, 0, 1'b1);
        e = {7'b0, exp_err.pop_front()};
        checks++; if (rsp_pulses != 1 || {got_rdata, got_err} !== {exp_rdata.pop_front(), e[0]}) begin
            failures++; $display("FAIL mid_recover_rsp got=%0d/%h/%b exp=1/cafef00d/0", rsp_pulses, got_rdata, got_err);
        end
    endtask

    // Scenario sequence
    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.m_axis_tready = 1'b1; bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = 8'h00;
        test_reset;
        test_write;
        test_read;
        test_stall;
        test_errors;
        test_stray;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
